// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the command sequencer.
package cmd_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_SENT,
        WAIT_RESP,
        WAIT_DN,
        ERR
    } state_e;

    // err_code values
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TX_TMO  = 2'b01;
    localparam logic [1:0] ERR_RSP_TMO = 2'b10;
    localparam logic [1:0] ERR_NAK     = 2'b11;

    // Default response bytes sent back by the Knight
    localparam logic [7:0] RESP_ACK  = 8'h5A;
    localparam logic [7:0] RESP_DONE = 8'hA5;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: circular buffer, wrapping pointers, extra-bit occupancy count.
// DEPTH must be a power of two so the pointers wrap for free.
module cmd_fifo #(
    parameter int CMD_W = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [CMD_W-1:0]         push_data,
    input  logic                     pop,
    output logic [CMD_W-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][CMD_W-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic                        push_ok;
    logic                        pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cmd_seq_ctrl.sv
// Command sequencer: queues host commands, issues them one at a time to the
// transmitter, waits for the response byte, retries on NAK/response timeout
// and latches a sticky error when out of retries.
// Optional build macro CMD_SEQ_STATS_EN adds stat_sent/stat_retry counters.
module cmd_seq_ctrl
    import cmd_seq_pkg::*;
#(
    parameter int         CMD_W     = 16,
    parameter int         DEPTH     = 8,
    parameter int         TMO_CYC   = 1000000,
    parameter int         RETRIES   = 2,
    parameter logic [7:0] ACK_CODE  = RESP_ACK,
    parameter logic [7:0] DONE_CODE = RESP_DONE,
    parameter int         WAIT_DONE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [CMD_W-1:0]       push_cmd,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   send_cmd,
    output logic [CMD_W-1:0]       cmd,
    input  logic                   cmd_sent,
    input  logic                   resp_rdy,
    input  logic [7:0]             resp,
    input  logic                   clr_err,
    output logic                   busy,
    output logic                   cmd_done,
    output logic                   err,
    output logic [1:0]             err_code
`ifdef CMD_SEQ_STATS_EN
    ,
    output logic [15:0]            stat_sent,
    output logic [15:0]            stat_retry
`endif
);
    localparam int             TW        = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TMO_CYC - 1);
    localparam int             RW        = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
    localparam logic [RW-1:0]  RETRY_MAX = RW'(RETRIES);

    state_e            state, state_nxt;
    logic [TW-1:0]     tmr;
    logic [RW-1:0]     retry;
    logic [CMD_W-1:0]  head;
    logic              sent_d;
    logic              sent_rise;
    logic              tmo;
    logic              pop;
    logic              tmr_clr;
    logic              retry_inc;
    logic              retry_clr;
    logic              err_set;
    logic              err_clr;
    logic              done_set;
    logic [1:0]        code_nxt;

    cmd_fifo #(
        .CMD_W (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign sent_rise = cmd_sent && !sent_d;
    assign tmo       = (tmr == TMO_LAST);
    assign busy      = (state != IDLE);

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tmr_clr   = 1'b0;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        done_set  = 1'b0;
        code_nxt  = ERR_NONE;
        case (state)
            IDLE: begin
                if (!empty && !err) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                tmr_clr   = 1'b1;
                state_nxt = WAIT_SENT;
            end
            WAIT_SENT: begin
                if (sent_rise) begin
                    tmr_clr   = 1'b1;
                    state_nxt = WAIT_RESP;
                end else if (tmo) begin
                    // stuck transmitter: re-sending would not help
                    err_set   = 1'b1;
                    code_nxt  = ERR_TX_TMO;
                    state_nxt = ERR;
                end
            end
            WAIT_RESP: begin
                if (resp_rdy && resp == ACK_CODE) begin
                    if (WAIT_DONE == 0) begin
                        pop       = 1'b1;
                        done_set  = 1'b1;
                        retry_clr = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        tmr_clr   = 1'b1;
                        state_nxt = WAIT_DN;
                    end
                end else if (resp_rdy || tmo) begin
                    // a response arriving on the timeout cycle is judged as a response
                    if (retry < RETRY_MAX) begin
                        retry_inc = 1'b1;
                        state_nxt = LAUNCH;
                    end else begin
                        err_set   = 1'b1;
                        code_nxt  = resp_rdy ? ERR_NAK : ERR_RSP_TMO;
                        state_nxt = ERR;
                    end
                end
            end
            WAIT_DN: begin
                if (resp_rdy && resp == DONE_CODE) begin
                    pop       = 1'b1;
                    done_set  = 1'b1;
                    retry_clr = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo) begin
                    // move already acknowledged, so no re-send
                    err_set   = 1'b1;
                    code_nxt  = ERR_RSP_TMO;
                    state_nxt = ERR;
                end
            end
            ERR: begin
                if (clr_err) begin
                    err_clr   = 1'b1;
                    retry_clr = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, timer, retry counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tmr      <= '0;
            retry    <= '0;
            sent_d   <= 1'b0;
            send_cmd <= 1'b0;
            cmd      <= '0;
            cmd_done <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_nxt;
            sent_d   <= cmd_sent;
            send_cmd <= (state == LAUNCH);
            cmd_done <= done_set;
            if (state == LAUNCH) cmd <= head;
            // timer saturates rather than wrapping
            if (tmr_clr)         tmr <= '0;
            else if (tmr != '1)  tmr <= tmr + 1'b1;
            if (retry_clr)       retry <= '0;
            else if (retry_inc)  retry <= retry + 1'b1;
            if (err_set) begin
                err      <= 1'b1;
                err_code <= code_nxt;
            end else if (err_clr) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end
        end
    end

`ifdef CMD_SEQ_STATS_EN
    // Saturating activity counters; observation only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_sent  <= '0;
            stat_retry <= '0;
        end else if (clr_err) begin
            stat_sent  <= '0;
            stat_retry <= '0;
        end else begin
            if (send_cmd && stat_sent != 16'hFFFF)   stat_sent  <= stat_sent + 1'b1;
            if (retry_inc && stat_retry != 16'hFFFF) stat_retry <= stat_retry + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cmd_seq_ctrl.sv
// Directed bench for cmd_seq_ctrl. Two instances share all inputs: dut0 is
// ack-only, dut1 waits for the done byte. sel picks which one is observed.
module tb_cmd_seq_ctrl;
    localparam int W   = 16;
    localparam int D   = 4;
    localparam int TMO = 100;
    localparam int CW  = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic [W-1:0]  push_cmd = '0;
    logic          cmd_sent = 1'b0;
    logic          resp_rdy = 1'b0;
    logic [7:0]    resp = '0;
    logic          clr_err = 1'b0;
    logic          sel = 1'b0;

    logic [1:0]          full_v, empty_v, send_v, busy_v, done_v, err_v;
    logic [1:0][CW-1:0]  count_v;
    logic [1:0][W-1:0]   cmd_v;
    logic [1:0][1:0]     code_v;

    wire          full     = full_v[sel];
    wire          empty    = empty_v[sel];
    wire          send_cmd = send_v[sel];
    wire          busy     = busy_v[sel];
    wire          cmd_done = done_v[sel];
    wire          err      = err_v[sel];
    wire [CW-1:0] count    = count_v[sel];
    wire [W-1:0]  cmd      = cmd_v[sel];
    wire [1:0]    err_code = code_v[sel];

    int n_chk  = 0;
    int n_fail = 0;
    int n_send = 0;
    int s0;

    always #5 clk = ~clk;

    cmd_seq_ctrl #(.CMD_W(W), .DEPTH(D), .TMO_CYC(TMO), .RETRIES(2),
                   .ACK_CODE(8'h5A), .DONE_CODE(8'hA5), .WAIT_DONE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .push(push), .push_cmd(push_cmd),
        .full(full_v[0]), .empty(empty_v[0]), .count(count_v[0]),
        .send_cmd(send_v[0]), .cmd(cmd_v[0]), .cmd_sent(cmd_sent),
        .resp_rdy(resp_rdy), .resp(resp), .clr_err(clr_err),
        .busy(busy_v[0]), .cmd_done(done_v[0]), .err(err_v[0]), .err_code(code_v[0])
    );

    cmd_seq_ctrl #(.CMD_W(W), .DEPTH(D), .TMO_CYC(TMO), .RETRIES(2),
                   .ACK_CODE(8'h5A), .DONE_CODE(8'hA5), .WAIT_DONE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .push(push), .push_cmd(push_cmd),
        .full(full_v[1]), .empty(empty_v[1]), .count(count_v[1]),
        .send_cmd(send_v[1]), .cmd(cmd_v[1]), .cmd_sent(cmd_sent),
        .resp_rdy(resp_rdy), .resp(resp), .clr_err(clr_err),
        .busy(busy_v[1]), .cmd_done(done_v[1]), .err(err_v[1]), .err_code(code_v[1])
    );

    // count send_cmd pulses of the observed instance
    always @(negedge clk) if (send_cmd) n_send <= n_send + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_push(input logic [W-1:0] c);
        push = 1'b1; push_cmd = c; tick(); push = 1'b0;
    endtask

    task automatic wait_send(input string tag);
        for (int i = 0; i < 300 && !send_cmd; i++) tick();
        chk(tag, send_cmd, 1'b1);
    endtask

    task automatic wait_err(input string tag);
        for (int i = 0; i < 1000 && !err; i++) tick();
        chk(tag, err, 1'b1);
    endtask

    task automatic pulse_sent();
        cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    endtask

    task automatic respond(input logic [7:0] b);
        resp_rdy = 1'b1; resp = b; tick(); resp_rdy = 1'b0;
    endtask

    task automatic clear();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
    endtask

    task automatic finish_ok(input string tag, input logic [W-1:0] c);
        wait_send({tag, "_send"});
        chk({tag, "_cmd"}, cmd, c);
        pulse_sent();
        respond(8'h5A);
        chk({tag, "_done"}, cmd_done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_send", send_cmd, 1'b0);
        chk("rst_cmd", cmd, 0);
        chk("rst_err", {err, err_code}, 3'b000);
        rst_n = 1'b1;
        tick();

        // wait-for-done mode: ACK alone does not complete, other bytes ignored
        sel = 1'b1;
        do_push(16'h5505);
        wait_send("dn_send");
        chk("dn_cmd", cmd, 16'h5505);
        pulse_sent();
        respond(8'h5A);
        chk("dn_ack_nodone", cmd_done, 1'b0);
        chk("dn_ack_busy", busy, 1'b1);
        respond(8'h11);
        chk("dn_11_nodone", cmd_done, 1'b0);
        chk("dn_11_count", count, 1);
        respond(8'hA5);
        chk("dn_done", cmd_done, 1'b1);
        chk("dn_empty", empty, 1'b1);
        tick();
        sel = 1'b0;
        tick();

        // single command, ack-only
        s0 = n_send;
        do_push(16'h2A01);
        finish_ok("t1", 16'h2A01);
        chk("t1_empty", empty, 1'b1);
        chk("t1_err", err, 1'b0);
        tick(); tick();
        chk("t1_nsend", n_send - s0, 1);

        // three back-to-back commands, strict order
        do_push(16'h1111);
        do_push(16'h2222);
        do_push(16'h3333);
        chk("t2_count3", count, 3);
        finish_ok("t2a", 16'h1111);
        chk("t2_count2", count, 2);
        finish_ok("t2b", 16'h2222);
        chk("t2_count1", count, 1);
        finish_ok("t2c", 16'h3333);
        chk("t2_count0", count, 0);

        // NAK twice then ACK: three sends of the same command
        tick();
        s0 = n_send;
        do_push(16'h3C03);
        for (int k = 0; k < 2; k++) begin
            wait_send("t3_send");
            chk("t3_cmd", cmd, 16'h3C03);
            pulse_sent();
            respond(8'h00);
            chk("t3_noerr", err, 1'b0);
        end
        finish_ok("t3_ok", 16'h3C03);
        chk("t3_err", err, 1'b0);
        tick(); tick();
        chk("t3_nsend", n_send - s0, 3);

        // NAK three times: retries exhausted
        do_push(16'h3D03);
        for (int k = 0; k < 3; k++) begin
            wait_send("t3x_send");
            pulse_sent();
            respond(8'h00);
        end
        chk("t3x_err", err, 1'b1);
        chk("t3x_code", err_code, 2'b11);
        chk("t3x_count", count, 1);
        chk("t3x_busy", busy, 1'b1);
        clear();
        chk("t3x_clr", {err, err_code}, 3'b000);
        finish_ok("t3x_reissue", 16'h3D03);

        // transmitter never finishes: error exactly TMO cycles after send_cmd
        tick();
        do_push(16'h4C04);
        wait_send("t4_send");
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("t4_early", err, 1'b0);
        tick();
        chk("t4_err", err, 1'b1);
        chk("t4_code", err_code, 2'b01);
        chk("t4_busy", busy, 1'b1);
        repeat (3) tick();
        chk("t4_hold", send_cmd, 1'b0);
        clear();
        finish_ok("t4_reissue", 16'h4C04);

        // no response: two retries then response timeout
        tick();
        s0 = n_send;
        do_push(16'h4D04);
        for (int k = 0; k < 3; k++) begin
            wait_send("tr_send");
            pulse_sent();
        end
        wait_err("tr_err");
        chk("tr_code", err_code, 2'b10);
        chk("tr_nsend", n_send - s0, 3);
        clear();
        finish_ok("tr_reissue", 16'h4D04);

        // fill past depth: last push dropped
        tick();
        for (int k = 0; k < D + 1; k++) do_push(16'hF000 + W'(k));
        chk("t6_full", full, 1'b1);
        chk("t6_count", count, D);
        chk("t6_head_cmd", cmd, 16'hF000);
        pulse_sent();
        respond(8'h5A);
        chk("t6_done0", cmd_done, 1'b1);
        for (int k = 1; k < D; k++) finish_ok("t6_drain", 16'hF000 + W'(k));
        s0 = n_send;
        repeat (5) tick();
        chk("t6_empty", empty, 1'b1);
        chk("t6_nodrop", n_send - s0, 0);

        // asynchronous reset while waiting for a response
        do_push(16'h7777);
        wait_send("t7_send");
        pulse_sent();
        chk("t7_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_busy_rst", busy, 1'b0);
        chk("t7_count_rst", count, 0);
        chk("t7_empty_rst", empty, 1'b1);
        chk("t7_cmd_rst", cmd, 0);
        chk("t7_err_rst", {err, err_code}, 3'b000);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
